// File: rtl/seq_detector_param_if.sv
// Serial-detector bus: configuration, qualified bit stream, match outputs and debug state.
// Handshake: x is consumed on a rising clk edge only when en=1; there is no backpressure.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
);
  logic             en;
  logic             x;
  logic             cfg_load;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             moore;
  logic             clr_cnt;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] dbg_fill;
  logic [LEN_W-1:0] dbg_len;

  modport master (
    output en, x, cfg_load, pat, pat_len, overlap, moore, clr_cnt,
    input  z, match_cnt, dbg_fill, dbg_len
  );

  modport slave (
    input  en, x, cfg_load, pat, pat_len, overlap, moore, clr_cnt,
    output z, match_cnt, dbg_fill, dbg_len
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with Mealy/Moore output,
// optional overlap and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  det_if
);
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] cfg_pat_q;
  logic [LEN_W-1:0] cfg_len_q;
  logic             cfg_ovl_q;
  logic             cfg_moore_q;
  logic             z_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] eff_len;
  logic             match;

  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], det_if.x};
    fill_d   = (fill_q >= PAT_W_L) ? PAT_W_L : fill_q + LEN_W'(1);
    // Bits above cfg_len are masked so stale history never affects the compare.
    len_mask = ~({PAT_W{1'b1}} << cfg_len_q);
    eff_len  = (det_if.pat_len > PAT_W_L) ? PAT_W_L : det_if.pat_len;
    match    = det_if.en & ~det_if.cfg_load
             & (cfg_len_q >= LEN_W'(2))
             & (fill_d >= cfg_len_q)
             & (((hist_d ^ cfg_pat_q) & len_mask) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q      <= '0;
      fill_q      <= '0;
      cfg_pat_q   <= '0;
      cfg_len_q   <= '0;
      cfg_ovl_q   <= 1'b1;
      cfg_moore_q <= 1'b0;
      z_q         <= 1'b0;
    end else if (det_if.cfg_load) begin
      hist_q      <= '0;
      fill_q      <= '0;
      cfg_pat_q   <= det_if.pat;
      cfg_len_q   <= eff_len;
      cfg_ovl_q   <= det_if.overlap;
      cfg_moore_q <= det_if.moore;
      z_q         <= 1'b0;
    end else if (det_if.en) begin
      z_q <= match;
      if (match && !cfg_ovl_q) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end else if (cfg_moore_q) begin
      z_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (det_if.clr_cnt) begin
      cnt_q <= '0;
    end else if (match && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign det_if.z         = cfg_moore_q ? z_q : match;
  assign det_if.match_cnt = cnt_q;
  assign det_if.dbg_fill  = fill_q;
  assign det_if.dbg_len   = cfg_len_q;
endmodule
